// File: rtl/sha256unit_pkt_tx_pkg.sv
// Shared definitions for the sha256unit input-stream feeder: packet codes,
// field lengths, FSM states and the latched candidate record.
package sha256unit_pkt_tx_pkg;

  localparam int unsigned UNIT_INPUT_WIDTH = 8;

  localparam logic [2:0] PKT_TYPE_DATA = 3'b000;
  localparam logic [2:0] PKT_TYPE_INIT = 3'b001;

  localparam int unsigned CNT_LEN  = 4;
  localparam int unsigned SLEN_LEN = 4;
  localparam int unsigned SALT_LEN = 16;
  localparam int unsigned IDS_LEN  = 8;
  localparam int unsigned KLEN_LEN = 8;
  localparam int unsigned KEY_MAX  = 64;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_HDR, S_CNT, S_SLEN, S_SALT, S_IDS, S_KLEN, S_KEY, S_END
  } state_t;

  typedef struct packed {
    logic [31:0]  cnt;
    logic [7:0]   salt_len;
    logic [127:0] salt;
    logic [63:0]  ids;
    logic [6:0]   key_len;
    logic [511:0] key;
  } rec_t;

  // Index of the final byte of the field emitted in state s.
  function automatic logic [5:0] field_last(input state_t s, input logic [6:0] key_len);
    logic [6:0] padded;
    padded = (key_len + 7'd3) & 7'h7C;
    case (s)
      S_CNT:   return 6'(CNT_LEN - 1);
      S_SLEN:  return 6'(SLEN_LEN - 1);
      S_SALT:  return 6'(SALT_LEN - 1);
      S_IDS:   return 6'(IDS_LEN - 1);
      S_KLEN:  return 6'(KLEN_LEN - 1);
      S_KEY:   return 6'(padded - 7'd1);
      default: return '0;
    endcase
  endfunction

  function automatic state_t next_field(input state_t s, input logic [6:0] key_len);
    case (s)
      S_HDR:   return S_CNT;
      S_CNT:   return S_SLEN;
      S_SLEN:  return S_SALT;
      S_SALT:  return S_IDS;
      S_IDS:   return S_KLEN;
      S_KLEN:  return (key_len == '0) ? S_END : S_KEY;
      S_KEY:   return S_END;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sha256unit_pkt_tx_mux.sv
// Combinational byte selector: picks the current stream byte from the latched
// record by state and byte counter, zeroing bytes beyond salt/key length.
module sha256unit_pkt_tx_mux
  import sha256unit_pkt_tx_pkg::*;
(
  input  state_t      state_i,
  input  logic [5:0]  ctr_i,
  input  rec_t        rec_i,
  input  logic [4:0]  init_data_i,
  output logic [7:0]  byte_o
);

  always_comb begin
    byte_o = '0;
    case (state_i)
      S_INIT:       byte_o = {init_data_i, PKT_TYPE_INIT};
      S_HDR, S_END: byte_o = {5'd0, PKT_TYPE_DATA};
      S_CNT:        byte_o = rec_i.cnt[{ctr_i[1:0], 3'b000} +: 8];
      S_SLEN:       if (ctr_i == '0) byte_o = rec_i.salt_len;
      S_SALT:       if ({2'b00, ctr_i} < rec_i.salt_len)
                      byte_o = rec_i.salt[{ctr_i[3:0], 3'b000} +: 8];
      S_IDS:        byte_o = rec_i.ids[{ctr_i[2:0], 3'b000} +: 8];
      S_KLEN:       if (ctr_i == '0) byte_o = {1'b0, rec_i.key_len};
      S_KEY:        if ({1'b0, ctr_i} < rec_i.key_len)
                      byte_o = rec_i.key[{ctr_i, 3'b000} +: 8];
      default:      byte_o = '0;
    endcase
  end

endmodule

// File: rtl/sha256unit_pkt_tx.sv
// Feeder for one sha256unit: serializes candidate records and init requests
// into the unit's byte-wide ctrl-framed stream, honouring ready and afull.
module sha256unit_pkt_tx #(
  parameter int unsigned UNIT_INPUT_WIDTH = 8,
  parameter int unsigned AFULL_SLACK      = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        rec_valid,
  output logic                        rec_ready,
  input  logic [31:0]                 cnt,
  input  logic [7:0]                  salt_len,
  input  logic [127:0]                salt,
  input  logic [63:0]                 ids,
  input  logic [6:0]                  key_len,
  input  logic [511:0]                key,
  input  logic                        init_req,
  input  logic [4:0]                  init_data,
  output logic                        init_ack,
  output logic [UNIT_INPUT_WIDTH-1:0] unit_in,
  output logic                        unit_in_ctrl,
  output logic                        unit_in_wr_en,
  input  logic                        unit_in_afull,
  input  logic                        unit_in_ready,
  output logic                        busy
);
  import sha256unit_pkt_tx_pkg::*;

  if (UNIT_INPUT_WIDTH != 8 || AFULL_SLACK < 1) begin : g_cfg_check
    $error("sha256unit_pkt_tx: only 8-bit unit input with nonzero afull slack is supported");
  end

  state_t     state_q, state_d;
  logic [5:0] ctr_q, ctr_d;
  rec_t       rec_q, rec_d;
  logic [4:0] init_q, init_d;
  logic       rec_ready_q, rec_ready_d;
  logic       init_ack_q, init_ack_d;
  logic       busy_q, busy_d;
  logic       wr_en_q, wr_en_d;
  logic       ctrl_q, ctrl_d;
  logic [UNIT_INPUT_WIDTH-1:0] data_q, data_d;
  logic [7:0] mux_byte;
  logic [5:0] last;

  sha256unit_pkt_tx_mux u_mux (
    .state_i     (state_q),
    .ctr_i       (ctr_q),
    .rec_i       (rec_q),
    .init_data_i (init_q),
    .byte_o      (mux_byte)
  );

  // afull seen at an edge suppresses the write registered on that edge, so
  // no word is written after afull has been sampled; state and counter hold.
  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    rec_d       = rec_q;
    init_d      = init_q;
    rec_ready_d = 1'b0;
    init_ack_d  = 1'b0;
    busy_d      = 1'b0;
    wr_en_d     = 1'b0;
    ctrl_d      = 1'b0;
    data_d      = data_q;
    last        = field_last(state_q, rec_q.key_len);
    case (state_q)
      S_IDLE: begin
        if (init_req) begin
          init_d  = init_data;
          state_d = S_INIT;
        end else if (rec_valid && unit_in_ready && !unit_in_afull) begin
          rec_ready_d    = 1'b1;
          busy_d         = 1'b1;
          state_d        = S_HDR;
          ctr_d          = '0;
          rec_d.cnt      = cnt;
          rec_d.salt_len = salt_len;
          rec_d.salt     = salt;
          rec_d.ids      = ids;
          rec_d.key_len  = (key_len > 7'(KEY_MAX)) ? 7'(KEY_MAX) : key_len;
          rec_d.key      = key;
        end
      end
      S_INIT: begin
        if (!unit_in_afull) begin
          wr_en_d    = 1'b1;
          ctrl_d     = 1'b1;
          data_d     = mux_byte;
          init_ack_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        busy_d = 1'b1;
        if (!unit_in_afull) begin
          wr_en_d = 1'b1;
          ctrl_d  = (state_q == S_HDR) || (state_q == S_END);
          data_d  = mux_byte;
          if (ctr_q == last) begin
            ctr_d   = '0;
            state_d = next_field(state_q, rec_q.key_len);
          end else begin
            ctr_d = ctr_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      ctr_q       <= '0;
      rec_q       <= '0;
      init_q      <= '0;
      rec_ready_q <= 1'b0;
      init_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      rec_q       <= rec_d;
      init_q      <= init_d;
      rec_ready_q <= rec_ready_d;
      init_ack_q  <= init_ack_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
    end
  end

  assign rec_ready     = rec_ready_q;
  assign init_ack      = init_ack_q;
  assign busy          = busy_q;
  assign unit_in_wr_en = wr_en_q;
  assign unit_in_ctrl  = ctrl_q;
  assign unit_in       = data_q;

endmodule

// File: doc/sha256unit_pkt_tx.md
Name: sha256unit_pkt_tx

Overview:
Upstream feeder for one sha256unit. It accepts one parallel candidate record (round count, salt, IDs, key) per handshake and serializes it into the unit's byte-wide, ctrl-framed input stream. It obeys unit_in_ready and unit_in_afull. It also issues single-word init packets. It sits between the arbiter's candidate queue and the unit's input FIFO.

Parameters:
UNIT_INPUT_WIDTH, 8, width of unit input word; only 8 is supported.
AFULL_SLACK, 4, words the unit FIFO still accepts after asserting afull; it bounds how many words may be written after afull is seen.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous, active-high reset.
rec_valid  in  1  candidate record present.
rec_ready  out  1  record accepted when rec_valid & rec_ready.
cnt  in  32  number of rounds.
salt_len  in  8  salt length, 1..16.
salt  in  128  salt bytes; byte k = salt[8k+7:8k]; unused bytes are don't-care.
ids  in  64  candidate IDs; byte k = ids[8k+7:8k].
key_len  in  7  key length, 0..64.
key  in  512  key bytes; byte k = key[8k+7:8k].
init_req  in  1  request an init packet.
init_data  in  5  init payload (entry point).
init_ack  out  1  one-cycle pulse when the init word is written.
unit_in  out  8  data word to unit.
unit_in_ctrl  out  1  framing flag.
unit_in_wr_en  out  1  write strobe.
unit_in_afull  in  1  unit FIFO almost full.
unit_in_ready  in  1  unit has an idle thread.
busy  out  1  packet in progress.

Behaviour:
- Reset values: rec_ready=0, init_ack=0, unit_in=0, unit_in_ctrl=0, unit_in_wr_en=0, busy=0, state=IDLE. All outputs are registered.
- Reset mid-packet: the stream is abandoned and wr_en is 0 from the next cycle. The unit side is also reset by the system.
- IDLE arbitration: init_req has priority over rec_valid.
- Init path: goes to INIT, writes one word {init_data,3'b001} with ctrl=1, pulses init_ack, then returns to IDLE. unit_in_ready is not checked for init.
- Record path: rec_ready pulses for exactly one cycle when rec_valid, ~init_req, unit_in_ready and ~unit_in_afull are all high. On that cycle the record is latched internally and the inputs become don't-care.
- Word sequence emitted after acceptance:
  - HDR: 1 word, 8'h00, ctrl=1.
  - CNT: 4 bytes, LSB first.
  - SLEN: salt_len, then 3 zero bytes.
  - SALT: 16 bytes; bytes with index >= salt_len are forced to 0.
  - IDS: 8 bytes.
  - KLEN: key_len zero-extended, then 7 zero bytes (key_len 32 bit + unused 32 bit).
  - KEY: ceil(key_len/4)*4 bytes; bytes with index >= key_len are forced to 0. key_len=0 emits no KEY bytes. key_len>64 is clamped to 64.
  - END: 1 word, 8'h00, ctrl=1.
  - Then return to IDLE.
- Packet length: 1+4+4+16+8+8+pad4(key_len)+1 words; 54 for key_len=12.
- A single 6-bit byte counter indexes the current field and is reset at each field boundary.
- Flow control:
  - unit_in_afull sampled high at edge t gives unit_in_wr_en=0 at t+1. The word is held and the counter is frozen.
  - The word resumes on the first cycle after afull is sampled low.
  - The words written after afull rises never exceed AFULL_SLACK; the design yields at most 1.
- unit_in_ready is checked only at packet start, never mid-packet.
- busy=1 from the acceptance cycle through the END write.
- The block never emits a word with wr_en=0 except during stalls.
- ctrl=1 appears only on HDR, END and INIT words.

Decomposition:
- Shared package/header (sha256.vh): UNIT_INPUT_WIDTH, packet type codes (PKT_TYPE_DATA=0, PKT_TYPE_INIT=3'b001), field lengths (CNT=4, SLEN=4, SALT=16, IDS=8, KLEN=8, KEY_MAX=64), state encodings.
- One natural sub-module: sha256unit_pkt_tx_mux. It is a combinational byte selector from (state, counter, latched record) to the output byte and applies the zero masks. The FSM, counter and handshake stay in the top module.

Test Plan:
- Record cnt=3, salt="saltstring" (len 10), ids=64'h0f0f0f0f0f0f0f0f, key="Hello world!" (len 12), afull=0 -> 54 consecutive wr_en cycles.
  - HDR 00/ctrl=1, then 03 00 00 00, 0A 00 00 00.
  - 10 salt bytes then 6 zeros, eight 0F.
  - 0C and 7 zeros, 12 key bytes, END ctrl=1.
- key_len=3, key="abc" -> KEY field = 61 62 63 00; total 46 words. key_len=0 -> no KEY words; 42 words.
- afull raised for 5 cycles during SALT byte 7 -> at most 1 extra write after the rise, wr_en=0 for the stall, salt byte 7 not duplicated or skipped, 54 words total.
- unit_in_ready=0 with rec_valid=1 -> rec_ready stays 0 and no writes. Raise ready -> rec_ready pulses once, then HDR follows.
- init_req=1, init_data=1 concurrent with rec_valid -> a single word 8'h09 with ctrl=1 and an init_ack pulse, then the record packet.
- RST asserted at word 20 of a packet -> all outputs 0 next cycle, state IDLE. A fresh record afterwards produces a correct full packet.
